// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg
//   Shared definitions for the AES inverse cipher round engine:
//   FSM state encodings, AES round-count constants, GF(2^8) multiply
//   helpers used by InvMixColumns, and the InvShiftRows byte permutation.
//   State layout everywhere: column-major, word 0 = bits 127:96,
//   row 0 of each column in the top byte of that word.
package aes_dec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_SBOX  = 3'd2,
        ST_MAIN  = 3'd3,
        ST_FINAL = 3'd4
    } dec_state_e;

    localparam int AES128_ROUNDS = 10;
    localparam int AES256_ROUNDS = 14;

    // Multiply by x (0x02) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

    // Row r rotates right by r columns: out(row r, col c) = in(row r, col c-r).
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        return {s[127:120], s[23:16],   s[47:40],   s[71:64],
                s[95:88],   s[119:112], s[15:8],    s[39:32],
                s[63:56],   s[87:80],   s[111:104], s[7:0],
                s[31:24],   s[55:48],   s[79:72],   s[103:96]};
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// aes_inv_mixcolumns
//   Purely combinational InvMixColumns over a full 128-bit state, one
//   column transform per 32-bit word. Also used by the decryption
//   key-schedule logic.
// Ports:
//   state_in   in  128  state before InvMixColumns
//   state_out  out 128  state after InvMixColumns
module aes_inv_mixcolumns
    import aes_dec_pkg::*;
(
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);

    // One column times the {0e 0b 0d 09} circulant matrix.
    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
                gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
                gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign state_out[127 - 32*c -: 32] = inv_mixw(state_in[127 - 32*c -: 32]);
    end

endmodule

// File: rtl/aes_decipher_block.sv
// aes_decipher_block
//   Iterative AES inverse cipher. One InvShiftRows/AddRoundKey(/InvMixColumns)
//   step per cycle plus a word-serial InvSubBytes through an external
//   shared 32-bit inverse S-box (four cycles per round).
//   Optional build macro AES_DEC_KEYLEN_EN adds a keylen input selecting
//   AES-128 (0) or AES-256 (1); without it the engine runs AES-256 only.
// Ports:
//   clk            in   1    system clock, rising edge
//   reset          in   1    asynchronous active-high reset
//   next           in   1    start pulse, only seen in IDLE
//   keylen         in   1    (AES_DEC_KEYLEN_EN only) 0=AES-128, 1=AES-256
//   round          out  4    round key index requested from key memory
//   round_key      in   128  round key for `round`, same cycle
//   inv_sboxw      out  32   state word being substituted
//   new_inv_sboxw  in   32   inverse S-box result for inv_sboxw
//   block          in   128  ciphertext, stable from next through INIT
//   new_block      out  128  working state, plaintext once ready=1
//   ready          out  1    idle with valid result, or after reset
module aes_decipher_block
    import aes_dec_pkg::*;
#(
    parameter int NUM_ROUNDS = AES256_ROUNDS,
    parameter int SBOX_WORDS = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
`ifdef AES_DEC_KEYLEN_EN
    input  logic         keylen,
`endif
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  inv_sboxw,
    input  logic [31:0]  new_inv_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [1:0] LAST_WORD = 2'(SBOX_WORDS - 1);

    dec_state_e   state_reg, state_next;
    logic [127:0] block_reg, block_next;
    logic [3:0]   round_ctr_reg, round_next;
    logic [1:0]   word_ctr_reg, word_next;
    logic         ready_reg, ready_next;

    logic [127:0] add_key;
    logic [127:0] mix_out;
    logic [3:0]   start_round;

    assign add_key = block_reg ^ round_key;

    aes_inv_mixcolumns u_inv_mix (
        .state_in  (add_key),
        .state_out (mix_out)
    );

`ifdef AES_DEC_KEYLEN_EN
    assign start_round = keylen ? 4'(NUM_ROUNDS) : 4'(AES128_ROUNDS);
`else
    assign start_round = 4'(NUM_ROUNDS);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            block_reg     <= '0;
            round_ctr_reg <= '0;
            word_ctr_reg  <= '0;
            ready_reg     <= 1'b1;
        end else begin
            state_reg     <= state_next;
            block_reg     <= block_next;
            round_ctr_reg <= round_next;
            word_ctr_reg  <= word_next;
            ready_reg     <= ready_next;
        end
    end

    // Word 0 is the most significant word of the state.
    always_comb begin
        inv_sboxw = block_reg[127:96];
        case (word_ctr_reg)
            2'd0:    inv_sboxw = block_reg[127:96];
            2'd1:    inv_sboxw = block_reg[95:64];
            2'd2:    inv_sboxw = block_reg[63:32];
            default: inv_sboxw = block_reg[31:0];
        endcase
    end

    always_comb begin
        state_next = state_reg;
        block_next = block_reg;
        round_next = round_ctr_reg;
        word_next  = word_ctr_reg;
        ready_next = ready_reg;

        case (state_reg)
            ST_IDLE: begin
                if (next) begin
                    round_next = start_round;
                    ready_next = 1'b0;
                    state_next = ST_INIT;
                end
            end

            ST_INIT: begin
                block_next = inv_shiftrows(block ^ round_key);
                round_next = round_ctr_reg - 4'd1;
                word_next  = 2'd0;
                state_next = ST_SBOX;
            end

            ST_SBOX: begin
                case (word_ctr_reg)
                    2'd0:    block_next[127:96] = new_inv_sboxw;
                    2'd1:    block_next[95:64]  = new_inv_sboxw;
                    2'd2:    block_next[63:32]  = new_inv_sboxw;
                    default: block_next[31:0]   = new_inv_sboxw;
                endcase
                word_next = word_ctr_reg + 2'd1;
                // Round 0 has no InvMixColumns step, only the last key add.
                if (word_ctr_reg == LAST_WORD) begin
                    state_next = (round_ctr_reg != 4'd0) ? ST_MAIN : ST_FINAL;
                end
            end

            ST_MAIN: begin
                block_next = inv_shiftrows(mix_out);
                round_next = round_ctr_reg - 4'd1;
                state_next = ST_SBOX;
            end

            ST_FINAL: begin
                block_next = add_key;
                ready_next = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign round     = round_ctr_reg;
    assign new_block = block_reg;
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher_block.sv
// tb_aes_decipher_block
//   Directed bench for aes_decipher_block. Supplies the key memory and the
//   inverse S-box from tables built here, and checks FIPS-197 vectors,
//   latency, round trace, next handling and mid-run reset.
module tb_aes_decipher_block;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P2     = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         clk;
    logic         reset;
    logic         next;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  inv_sboxw;
    logic [31:0]  new_inv_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;
`ifdef AES_DEC_KEYLEN_EN
    logic         keylen;
`endif

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [31:0]  w     [60];
    logic [127:0] key_mem [15];

    int cmp_count;
    int err_count;

    aes_decipher_block dut (
        .clk           (clk),
        .reset         (reset),
        .next          (next),
`ifdef AES_DEC_KEYLEN_EN
        .keylen        (keylen),
`endif
        .round         (round),
        .round_key     (round_key),
        .inv_sboxw     (inv_sboxw),
        .new_inv_sboxw (new_inv_sboxw),
        .block         (block),
        .new_block     (new_block),
        .ready         (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign round_key     = key_mem[round];
    assign new_inv_sboxw = {isbox[inv_sboxw[31:24]], isbox[inv_sboxw[23:16]],
                            isbox[inv_sboxw[15:8]],  isbox[inv_sboxw[7:0]]};

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF inverse followed by the affine map.
    task automatic buildSboxes();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // nk = 4 (AES-128, key in the top 128 bits) or 8 (AES-256).
    task automatic expandKey(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < nk + 7; r++)
            key_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher, used only to make extra ciphertexts with known plaintext.
    task automatic encryptModel(input logic [127:0] pt_in, input int nr,
                                output logic [127:0] ct_out);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] x;
        x = pt_in ^ key_mem[0];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[x[127 - 8*i -: 8]];
            for (int i = 0; i < 16; i++) t[i] = s[4 * (((i / 4) + (i % 4)) % 4) + (i % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r != nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) x[127 - 8*i -: 8] = s[i];
            x = x ^ key_mem[r];
        end
        ct_out = x;
    endtask

    // Called at a negedge; next is sampled on the following posedge (E0).
    task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] exp_pt,
                                 input int nr, input int exp_lat, input bit trace_on,
                                 input string tag);
        int  n;
        int  exp_round;
        bit  done;
        block = ct;
        next  = 1'b1;
        n     = 0;
        done  = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            next = 1'b0;
            n++;
            if (trace_on && n <= exp_lat) begin
                exp_round = (n == 1) ? nr : nr - 1 - (n - 2) / 5;
                checkOutput($sformatf("%s_round_n%0d", tag, n), 128'(round), 128'(exp_round));
            end
            if (ready) done = 1'b1;
        end
        checkOutput({tag, "_latency"}, 128'(n - 1), 128'(exp_lat));
        checkOutput({tag, "_result"}, new_block, exp_pt);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] c2;
        int ready_cnt;
        int n;

        cmp_count = 0;
        err_count = 0;
        reset = 1'b1;
        next  = 1'b0;
        block = '0;
`ifdef AES_DEC_KEYLEN_EN
        keylen = 1'b1;
`endif
        buildSboxes();
        expandKey(C3_KEY, 8);
        encryptModel(P2, 14, c2);

        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 128'(ready), 128'(1));
        checkOutput("reset_new_block", new_block, '0);
        checkOutput("reset_round", 128'(round), 128'(0));
        checkOutput("reset_inv_sboxw", 128'(inv_sboxw), 128'(0));
        reset = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("idle_hold_ready", 128'(ready), 128'(1));
        checkOutput("idle_hold_round", 128'(round), 128'(0));

        $display("[TB] FIPS-197 C.3 run with round trace");
        applyStimulus(C3_CT, PT, 14, 71, 1'b1, "c3");

        $display("[TB] back-to-back runs");
        applyStimulus(c2, P2, 14, 71, 1'b0, "b2b_p2");
        applyStimulus(C3_CT, PT, 14, 71, 1'b0, "b2b_c3");

        $display("[TB] next held high for 100 cycles");
        block     = C3_CT;
        next      = 1'b1;
        ready_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (ready) ready_cnt++;
            if (k == 71) checkOutput("hold_ready_71", 128'(ready), 128'(0));
            if (k == 72) begin
                checkOutput("hold_ready_72", 128'(ready), 128'(1));
                checkOutput("hold_result_72", new_block, PT);
            end
            if (k == 73) begin
                checkOutput("hold_ready_73", 128'(ready), 128'(0));
                checkOutput("hold_restart_round", 128'(round), 128'(14));
            end
        end
        next = 1'b0;
        checkOutput("hold_ready_count", 128'(ready_cnt), 128'(1));
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_second_done", 128'(n), 128'(44));
        checkOutput("hold_second_result", new_block, PT);

        $display("[TB] reset mid-run");
        block = C3_CT;
        next  = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            next = 1'b0;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_ready", 128'(ready), 128'(1));
        checkOutput("midreset_new_block", new_block, '0);
        checkOutput("midreset_round", 128'(round), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(C3_CT, PT, 14, 71, 1'b0, "after_reset");

`ifdef AES_DEC_KEYLEN_EN
        $display("[TB] AES-128 via keylen=0, FIPS-197 C.1");
        expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        keylen = 1'b0;
        applyStimulus(128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 10, 51, 1'b1, "c1");
        expandKey(C3_KEY, 8);
        keylen = 1'b1;
        applyStimulus(C3_CT, PT, 14, 71, 1'b0, "keylen1_c3");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
